// File: rtl/cam_search_pipe.sv
`default_nettype none
// ============================================================================
// Module      : cam_search_pipe
// Description : Masked-key CAM with auto/directed writes, pop-on-hit and a
//               single-entry back-pressurable result register.
// Revision    : 1.0
// ============================================================================
module cam_search_pipe #(
    parameter int CAM_DW = 32,
    parameter int CAM_KW = 8,
    parameter int CAM_AW = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic              wr_auto,
    input  logic [CAM_AW-1:0] wr_addr,
    input  logic [CAM_DW-1:0] wr_data,
    output logic [CAM_AW-1:0] wr_addr_o,
    input  logic              srch_valid,
    output logic              srch_ready,
    input  logic [CAM_KW-1:0] srch_key,
    input  logic [CAM_KW-1:0] srch_mask,
    input  logic              srch_pop,
    output logic              rslt_valid,
    input  logic              rslt_ready,
    output logic              rslt_hit,
    output logic              rslt_multi,
    output logic [CAM_AW-1:0] rslt_addr,
    output logic [CAM_DW-1:0] rslt_data,
    output logic [CAM_AW:0]   count,
    output logic              full,
    output logic              empty
);

    localparam int c_DEPTH = 1 << CAM_AW;

    logic [CAM_DW-1:0]  r_mem [c_DEPTH];
    logic [c_DEPTH-1:0] r_valid;
    logic [CAM_AW:0]    r_count;
    logic               r_rslt_valid;
    logic               r_rslt_hit;
    logic               r_rslt_multi;
    logic [CAM_AW-1:0]  r_rslt_addr;
    logic [CAM_DW-1:0]  r_rslt_data;

    logic [c_DEPTH-1:0] w_match;
    logic [CAM_AW-1:0]  w_hit_idx;
    logic [CAM_AW-1:0]  w_free_idx;
    logic               w_hit;
    logic               w_multi;
    logic               w_full;
    logic [CAM_AW-1:0]  w_wr_idx;
    logic               w_wr_fire;
    logic               w_srch_fire;
    logic               w_pop;
    logic               w_cnt_inc;
    logic               w_cnt_dec;
    logic [c_DEPTH-1:0] w_wr_onehot;
    logic [c_DEPTH-1:0] w_pop_onehot;

    genvar gi;
    generate
        for (gi = 0; gi < c_DEPTH; gi++) begin : g_match
            assign w_match[gi] = r_valid[gi] &
                ~|((r_mem[gi][CAM_DW-1 -: CAM_KW] ^ srch_key) & srch_mask);
        end
    endgenerate

    // Descending scan so the lowest index is the last (winning) assignment.
    always_comb begin
        w_hit_idx  = '0;
        w_free_idx = '0;
        for (int i = c_DEPTH - 1; i >= 0; i--) begin
            if (w_match[i]) begin
                w_hit_idx = CAM_AW'(i);
            end
            if (!r_valid[i]) begin
                w_free_idx = CAM_AW'(i);
            end
        end
    end

    assign w_hit   = |w_match;
    assign w_multi = |(w_match & (w_match - c_DEPTH'(1)));
    assign w_full  = (r_count == (CAM_AW + 1)'(c_DEPTH));

    assign wr_ready   = ~flush & (~wr_auto | ~w_full);
    assign srch_ready = ~flush & (~r_rslt_valid | rslt_ready);

    assign w_wr_idx    = wr_auto ? w_free_idx : wr_addr;
    assign w_wr_fire   = wr_valid & wr_ready;
    assign w_srch_fire = srch_valid & srch_ready;
    assign w_pop       = w_srch_fire & srch_pop & w_hit;

    assign w_wr_onehot  = w_wr_fire ? (c_DEPTH'(1) << w_wr_idx) : '0;
    assign w_pop_onehot = w_pop ? (c_DEPTH'(1) << w_hit_idx) : '0;

    // A pop that is overwritten in the same cycle leaves the entry valid.
    assign w_cnt_inc = w_wr_fire & ~r_valid[w_wr_idx];
    assign w_cnt_dec = w_pop & ~(w_wr_fire & (w_wr_idx == w_hit_idx));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= '0;
            r_count <= '0;
        end else if (flush) begin
            r_valid <= '0;
            r_count <= '0;
        end else begin
            r_valid <= (r_valid & ~w_pop_onehot) | w_wr_onehot;
            if (w_cnt_inc && !w_cnt_dec) begin
                r_count <= r_count + 1'b1;
            end else if (!w_cnt_inc && w_cnt_dec) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr_fire) begin
            r_mem[w_wr_idx] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rslt_valid <= 1'b0;
            r_rslt_hit   <= 1'b0;
            r_rslt_multi <= 1'b0;
            r_rslt_addr  <= '0;
            r_rslt_data  <= '0;
        end else if (flush) begin
            r_rslt_valid <= 1'b0;
            r_rslt_hit   <= 1'b0;
            r_rslt_multi <= 1'b0;
            r_rslt_addr  <= '0;
            r_rslt_data  <= '0;
        end else if (w_srch_fire) begin
            r_rslt_valid <= 1'b1;
            r_rslt_hit   <= w_hit;
            r_rslt_multi <= w_multi;
            r_rslt_addr  <= w_hit_idx;
            r_rslt_data  <= w_hit ? r_mem[w_hit_idx] : '0;
        end else if (rslt_ready) begin
            r_rslt_valid <= 1'b0;
        end
    end

    assign wr_addr_o  = w_wr_idx;
    assign rslt_valid = r_rslt_valid;
    assign rslt_hit   = r_rslt_hit;
    assign rslt_multi = r_rslt_multi;
    assign rslt_addr  = r_rslt_addr;
    assign rslt_data  = r_rslt_data;
    assign count      = r_count;
    assign full       = w_full;
    assign empty      = (r_count == '0);

endmodule
`default_nettype wire

// File: tb/tb_cam_search_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_cam_search_pipe
// Description : Directed bench for cam_search_pipe with a reference CAM model
//               and a queue of expected search results.
// Revision    : 1.0
// ============================================================================
module tb_cam_search_pipe;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        wr_valid;
    logic        wr_ready;
    logic        wr_auto;
    logic [3:0]  wr_addr;
    logic [31:0] wr_data;
    logic [3:0]  wr_addr_o;
    logic        srch_valid;
    logic        srch_ready;
    logic [7:0]  srch_key;
    logic [7:0]  srch_mask;
    logic        srch_pop;
    logic        rslt_valid;
    logic        rslt_ready;
    logic        rslt_hit;
    logic        rslt_multi;
    logic [3:0]  rslt_addr;
    logic [31:0] rslt_data;
    logic [4:0]  count;
    logic        full;
    logic        empty;

    cam_search_pipe #(.CAM_DW(32), .CAM_KW(8), .CAM_AW(4)) u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .wr_valid   (wr_valid),
        .wr_ready   (wr_ready),
        .wr_auto    (wr_auto),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .wr_addr_o  (wr_addr_o),
        .srch_valid (srch_valid),
        .srch_ready (srch_ready),
        .srch_key   (srch_key),
        .srch_mask  (srch_mask),
        .srch_pop   (srch_pop),
        .rslt_valid (rslt_valid),
        .rslt_ready (rslt_ready),
        .rslt_hit   (rslt_hit),
        .rslt_multi (rslt_multi),
        .rslt_addr  (rslt_addr),
        .rslt_data  (rslt_data),
        .count      (count),
        .full       (full),
        .empty      (empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        hit;
        logic        multi;
        logic [3:0]  addr;
        logic [31:0] data;
    } rslt_t;

    rslt_t       sb_q[$];
    bit          mdl_valid [16];
    logic [31:0] mdl_data  [16];
    int          n_checks;
    int          n_errors;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int mdl_count();
        int n = 0;
        for (int i = 0; i < 16; i++) n += mdl_valid[i] ? 1 : 0;
        return n;
    endfunction

    task automatic mdl_clear();
        for (int i = 0; i < 16; i++) mdl_valid[i] = 1'b0;
        sb_q.delete();
    endtask

    // Checks pre-edge outputs against the model, advances the model over one
    // clock edge, then checks the occupancy outputs after the edge.
    task automatic tick();
        bit    wacc;
        bit    sacc;
        int    widx;
        int    nm;
        rslt_t r;
        #1;
        if (sb_q.size() != 0) begin
            chk("rslt_valid", rslt_valid, 1);
            chk("rslt_hit", rslt_hit, sb_q[0].hit);
            chk("rslt_multi", rslt_multi, sb_q[0].multi);
            chk("rslt_addr", rslt_addr, sb_q[0].addr);
            chk("rslt_data", rslt_data, sb_q[0].data);
        end else begin
            chk("rslt_valid", rslt_valid, 0);
        end
        wacc = !flush && (!wr_auto || mdl_count() != 16);
        chk("wr_ready", wr_ready, wacc);
        wacc = wacc && wr_valid;
        sacc = !flush && (sb_q.size() == 0 || rslt_ready);
        chk("srch_ready", srch_ready, sacc);
        sacc = sacc && srch_valid;
        widx = int'(wr_addr);
        if (wr_auto) begin
            for (int i = 15; i >= 0; i--) if (!mdl_valid[i]) widx = i;
        end
        if (wacc) chk("wr_addr_o", wr_addr_o, widx);
        if (flush) begin
            mdl_clear();
        end else begin
            if (sb_q.size() != 0 && rslt_ready) void'(sb_q.pop_front());
            if (sacc) begin
                nm = 0;
                r.hit = 0; r.multi = 0; r.addr = 0; r.data = 0;
                for (int i = 0; i < 16; i++) begin
                    if (mdl_valid[i] && (((mdl_data[i][31:24] ^ srch_key) & srch_mask) == 8'h00)) begin
                        if (nm == 0) begin
                            r.hit  = 1;
                            r.addr = 4'(i);
                            r.data = mdl_data[i];
                        end
                        nm++;
                    end
                end
                r.multi = (nm > 1);
                sb_q.push_back(r);
                if (srch_pop && r.hit) mdl_valid[r.addr] = 1'b0;
            end
            if (wacc) begin
                mdl_valid[widx] = 1'b1;
                mdl_data[widx]  = wr_data;
            end
        end
        @(posedge clk);
        #1;
        chk("count", count, mdl_count());
        chk("full", full, mdl_count() == 16);
        chk("empty", empty, mdl_count() == 0);
    endtask

    initial begin
        n_checks   = 0;
        n_errors   = 0;
        rst_n      = 1'b0;
        flush      = 1'b0;
        wr_valid   = 1'b0;
        wr_auto    = 1'b0;
        wr_addr    = 4'd0;
        wr_data    = 32'd0;
        srch_valid = 1'b0;
        srch_key   = 8'd0;
        srch_mask  = 8'd0;
        srch_pop   = 1'b0;
        rslt_ready = 1'b0;
        mdl_clear();
        repeat (2) @(posedge clk);
        #1;
        chk("reset_rslt_valid", rslt_valid, 0);
        chk("reset_rslt_hit", rslt_hit, 0);
        chk("reset_rslt_multi", rslt_multi, 0);
        chk("reset_rslt_addr", rslt_addr, 0);
        chk("reset_rslt_data", rslt_data, 0);
        chk("reset_count", count, 0);
        chk("reset_empty", empty, 1);
        chk("reset_full", full, 0);
        rst_n = 1'b1;
        tick();

        // Two auto-allocated writes land in entries 0 and 1.
        wr_valid = 1'b1; wr_auto = 1'b1;
        wr_data = 32'hA100_0000; tick();
        wr_data = 32'hA200_0000; tick();
        wr_valid = 1'b0;
        chk("count_two", count, 2);
        chk("empty_two", empty, 0);

        // Masked search hitting both entries.
        srch_valid = 1'b1; srch_key = 8'hA0; srch_mask = 8'hF0; srch_pop = 1'b0;
        rslt_ready = 1'b1;
        tick();
        srch_valid = 1'b0;
        chk("first_hit", rslt_hit, 1);
        chk("first_multi", rslt_multi, 1);
        chk("first_addr", rslt_addr, 0);
        chk("first_data", rslt_data, 32'hA100_0000);
        tick();

        // Same search with pop while the consumer stalls for three cycles.
        srch_valid = 1'b1; srch_pop = 1'b1; rslt_ready = 1'b0;
        tick();
        chk("count_after_pop", count, 1);
        srch_pop = 1'b0;
        repeat (3) tick();
        srch_valid = 1'b0; rslt_ready = 1'b1;
        tick();

        // Fill the remaining 15 entries: 0, 2, 3, ... 15.
        wr_valid = 1'b1; wr_auto = 1'b1;
        for (int i = 0; i < 15; i++) begin
            wr_data = {8'(8'h50 + i), 24'(i)};
            tick();
        end
        chk("full_after_fill", full, 1);
        wr_data = 32'hDEAD_0000;
        tick();
        wr_auto = 1'b0; wr_addr = 4'd5; wr_data = 32'hC500_0005;
        tick();
        wr_valid = 1'b0;
        chk("count_overwrite", count, 16);

        // Pop entry 3 (key 0x52) while writing entry 3 in the same cycle.
        srch_valid = 1'b1; srch_key = 8'h52; srch_mask = 8'hFF; srch_pop = 1'b1;
        wr_valid = 1'b1; wr_auto = 1'b0; wr_addr = 4'd3; wr_data = 32'hBEEF_0003;
        tick();
        wr_valid = 1'b0; srch_pop = 1'b0;
        chk("popwr_count", count, 16);
        chk("popwr_addr", rslt_addr, 3);
        srch_key = 8'hBE;
        tick();
        chk("popwr_data", rslt_data, 32'hBEEF_0003);
        srch_key = 8'h00; srch_mask = 8'h00;
        tick();
        chk("mask0_multi", rslt_multi, 1);
        srch_key = 8'h00; srch_mask = 8'hFF;
        tick();
        chk("nohit_hit", rslt_hit, 0);
        chk("nohit_data", rslt_data, 0);
        srch_valid = 1'b0;
        tick();

        // Flush with a pending result and a concurrent write.
        srch_valid = 1'b1; srch_key = 8'h50; srch_mask = 8'hFF; rslt_ready = 1'b0;
        tick();
        flush = 1'b1; srch_pop = 1'b1;
        wr_valid = 1'b1; wr_addr = 4'd7; wr_data = 32'h7777_7777;
        tick();
        flush = 1'b0; wr_valid = 1'b0; srch_valid = 1'b0; srch_pop = 1'b0;
        chk("flush_count", count, 0);
        chk("flush_rslt_valid", rslt_valid, 0);
        rslt_ready = 1'b1; srch_valid = 1'b1; srch_mask = 8'h00;
        tick();
        srch_valid = 1'b0;
        chk("flush_no_write", rslt_hit, 0);
        tick();

        // Asynchronous reset with a pending result.
        wr_valid = 1'b1; wr_auto = 1'b1; wr_data = 32'h1234_5678;
        tick();
        wr_valid = 1'b0;
        srch_valid = 1'b1; srch_key = 8'h12; srch_mask = 8'hFF; rslt_ready = 1'b0;
        tick();
        srch_valid = 1'b0;
        #3 rst_n = 1'b0;
        #1;
        chk("areset_rslt_valid", rslt_valid, 0);
        chk("areset_count", count, 0);
        chk("areset_empty", empty, 1);
        mdl_clear();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        rslt_ready = 1'b1;
        tick();
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
